// File: rtl/reg_share_arbiter_pkg.sv
// Shared definitions for the round-robin shared-register write arbiter:
// FSM state encoding and the one-hot grant helper.
package reg_share_arbiter_pkg;

  // Widest requester vector the one-hot helper can produce.
  localparam int unsigned MAX_NREQ = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic [MAX_NREQ-1:0] onehot(input int unsigned idx);
    logic [MAX_NREQ-1:0] one;
    one = {{(MAX_NREQ-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

endpackage

// File: rtl/reg_share_arbiter_rr_pick.sv
// Combinational round-robin selector: first set req bit scanning upward
// from last+1, wrapping modulo NREQ.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last,
  output logic [IDW-1:0]  winner,
  output logic            any_req
);

  logic [IDW-1:0] idx;
  logic           found;

  // NOTE: every variable driven here gets a default first so no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    // Offset 1..NREQ visits last itself only after all other requesters.
    for (int i = 1; i <= NREQ; i++) begin
      idx = IDW'((int'(last) + i) % NREQ);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/reg_share_arbiter.sv
// Shares one WIDTH-bit register between NREQ requesters using a round-robin
// req/gnt/ack handshake; one write per three-cycle IDLE/LOAD/DONE pass.
module reg_share_arbiter
  import reg_share_arbiter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic                  ack,
  output logic [IDW-1:0]        owner,
  output logic                  busy,
  output logic [WIDTH-1:0]      data_out
);

  state_t           state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic             ack_q, ack_d;
  logic [IDW-1:0]   owner_q, owner_d;
  logic [IDW-1:0]   last_q, last_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] data_q, data_d;

  logic [IDW-1:0]   winner;
  logic             any_req;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_pick (
    .req     (req),
    .last    (last_q),
    .winner  (winner),
    .any_req (any_req)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ack_d   = 1'b0;
    owner_d = owner_q;
    last_d  = last_q;
    data_d  = data_q;

    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          owner_d = winner;
          gnt_d   = NREQ'(onehot(32'(winner)));
          state_d = S_LOAD;
        end else begin
          gnt_d = '0;
        end
      end
      S_LOAD: begin
        // A requester that withdrew before commit aborts without moving the
        // round-robin pointer, so its turn is not consumed.
        if (req[owner_q]) begin
          data_d  = wdata[int'(owner_q)*WIDTH +: WIDTH];
          last_d  = owner_q;
          ack_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          gnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        gnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  // The shared data word is a single register, so it is reset alongside the
  // control state rather than left uninitialised like a memory array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      ack_q   <= 1'b0;
      owner_q <= '0;
      last_q  <= IDW'(NREQ - 1);
      busy_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      data_q  <= data_d;
    end
  end

  assign gnt      = gnt_q;
  assign ack      = ack_q;
  assign owner    = owner_q;
  assign busy     = busy_q;
  assign data_out = data_q;

endmodule
